// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the registered CDB among the add/sub, multiply and divide groups
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          fu_valid,
  input  logic [3*TAG_W-1:0]  fu_tag,
  input  logic [3*DATA_W-1:0] fu_data,
  input  logic                cdb_hold,
  output logic [2:0]          fu_grant,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [1:0]          cdb_src,
  output logic [3*16-1:0]     grant_cnt
);
  logic [1:0] last, prio1, prio2, winIdx;
  logic doGrant;
  logic [15:0] cnt [3];
  always_comb begin
    prio1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    prio2 = (last == 2'd0) ? 2'd2 : last - 2'd1;
    winIdx = fu_valid[prio1] ? prio1 : fu_valid[prio2] ? prio2 : last;
    doGrant = |fu_valid && !cdb_hold && !rst;
    fu_grant = doGrant ? 3'b001 << winIdx : 3'b000;
  end
  assign grant_cnt = {cnt[2], cnt[1], cnt[0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 2'd2;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_src <= 2'd0;
      cnt <= '{default: 16'd0};
    end else begin
      cdb_valid <= doGrant;
      if (doGrant) begin
        last <= winIdx;
        cdb_src <= winIdx;
        cdb_tag <= fu_tag[winIdx*TAG_W +: TAG_W];
        cdb_data <= fu_data[winIdx*DATA_W +: DATA_W];
        cnt[winIdx] <= cnt[winIdx] + {15'd0, ~&cnt[winIdx]};
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a scoreboard queue of expected CDB broadcasts
module tb_cdb_arbiter;
  logic clk, rst, cdb_hold, cdb_valid;
  logic [2:0] fu_valid, fu_grant;
  logic [11:0] fu_tag;
  logic [95:0] fu_data;
  logic [3:0] cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0] cdb_src;
  logic [47:0] grant_cnt;
  typedef struct {logic v; logic [3:0] tag; logic [31:0] data; logic [1:0] src;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  cdb_arbiter dut (.clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .cdb_hold(cdb_hold), .fu_grant(fu_grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .grant_cnt(grant_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, check the combinational grant, queue the broadcast due next cycle
  task automatic step(input logic [2:0] v, input logic [11:0] tg, input logic [95:0] d,
                      input logic hold, input logic r, input logic [2:0] expGrant);
    exp_t e;
    int s;
    @(negedge clk);
    fu_valid = v; fu_tag = tg; fu_data = d; cdb_hold = hold; rst = r;
    #1;
    chk("fu_grant", {61'd0, fu_grant}, {61'd0, expGrant});
    s = expGrant == 3'b001 ? 0 : expGrant == 3'b010 ? 1 : 2;
    e.v = expGrant != 0;
    e.tag = tg[s*4 +: 4];
    e.data = d[s*32 +: 32];
    e.src = 2'(s);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, e.v});
      if (e.v) begin
        chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, e.tag});
        chk("cdb_data", {32'd0, cdb_data}, {32'd0, e.data});
        chk("cdb_src", {62'd0, cdb_src}, {62'd0, e.src});
      end
    end else if (cdb_valid) begin
      checks++;
      errors++;
      $display("FAIL unexpected_broadcast: cdb_valid=1 expected 0 at %0t", $time);
    end
  end

  localparam logic [11:0] T3 = {4'd3, 4'd2, 4'd1};

  initial begin
    rst = 1; cdb_hold = 0; fu_valid = 0; fu_tag = 0; fu_data = 0;
    step(3'b111, T3, 96'h1, 0, 1, 3'b000);
    step(3'b111, T3, 96'h1, 0, 1, 3'b000);
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    chk("reset_tag", {60'd0, cdb_tag}, 64'd0);
    chk("reset_data", {32'd0, cdb_data}, 64'd0);
    chk("reset_src", {62'd0, cdb_src}, 64'd0);
    chk("reset_cnt", {16'd0, grant_cnt}, 64'd0);
    step(3'b010, 12'h050, {32'd0, 32'hDEAD_BEEF, 32'd0}, 0, 0, 3'b010);
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    chk("single_cnt1", {48'd0, grant_cnt[31:16]}, 64'd1);
    step(3'b000, 12'd0, 96'd0, 0, 1, 3'b000);
    begin
      logic [2:0] rr [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 6; i++)
        step(3'b111, T3, {32'h300 + 32'(i), 32'h200 + 32'(i), 32'h100 + 32'(i)}, 0, 0, rr[i]);
    end
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    chk("rr_cnts", {16'd0, grant_cnt}, {16'd0, 16'd2, 16'd2, 16'd2});
    step(3'b001, 12'h901, {32'hC0, 32'd0, 32'hA0}, 0, 0, 3'b001);
    step(3'b001, 12'h902, {32'hC0, 32'd0, 32'hA1}, 0, 0, 3'b001);
    step(3'b001, 12'h903, {32'hC0, 32'd0, 32'hA2}, 0, 0, 3'b001);
    step(3'b101, 12'h904, {32'hC0, 32'd0, 32'hA3}, 0, 0, 3'b100);
    step(3'b001, 12'h904, {32'hC0, 32'd0, 32'hA3}, 0, 0, 3'b001);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 1, 0, 3'b000);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 1, 0, 3'b000);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 0, 0, 3'b010);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 0, 0, 3'b100);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 0, 0, 3'b001);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 0, 0, 3'b010);
    step(3'b100, T3, {32'h3, 32'h2, 32'h1}, 0, 1, 3'b000);
    step(3'b111, T3, {32'h3, 32'h2, 32'h1}, 0, 0, 3'b001);
    chk("rst_cnt_after", {16'd0, grant_cnt}, 64'd0);
    for (int i = 0; i < 65535; i++)
      step(3'b010, {4'd0, 4'(i % 15 + 1), 4'd0}, {32'd0, 32'(i), 32'd0}, 0, 0, 3'b010);
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    chk("sat_cnt1_at_max", {48'd0, grant_cnt[31:16]}, 64'hFFFF);
    for (int i = 0; i < 5; i++)
      step(3'b010, 12'h070, {32'd0, 32'h5A + 32'(i), 32'd0}, 0, 0, 3'b010);
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    chk("sat_cnts", {16'd0, grant_cnt}, {16'd0, 16'd0, 16'hFFFF, 16'd1});
    step(3'b000, 12'd0, 96'd0, 0, 0, 3'b000);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
